// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX boundary bundle: ID-stage decode results in, EX-stage operands out.
// The master drives the ID side; the slave is the pipeline register.
interface id_ex_pipe_reg_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
);
    logic             valid_i;
    logic             freeze_i;
    logic             flush_i;
    logic [6:0]       opcode_i;
    logic [9:0]       funct_i;
    logic [XLEN-1:0]  pc_i;
    logic [XLEN-1:0]  rs1_data_i;
    logic [XLEN-1:0]  rs2_data_i;
    logic [XLEN-1:0]  imm_i;
    logic [4:0]       rs1_addr_i;
    logic [4:0]       rs2_addr_i;
    logic [4:0]       rd_addr_i;
    logic             reg_write_i;
    logic             mem_to_reg_i;
    logic             mem_read_i;
    logic             mem_write_i;
    logic             alu_src_i;
    logic [1:0]       alu_op_i;

    logic             valid_o;
    logic [XLEN-1:0]  pc_o;
    logic [XLEN-1:0]  rs1_data_o;
    logic [XLEN-1:0]  rs2_data_o;
    logic [XLEN-1:0]  imm_o;
    logic [9:0]       funct_o;
    logic [4:0]       rs1_addr_o;
    logic [4:0]       rs2_addr_o;
    logic [4:0]       rd_addr_o;
    logic             reg_write_o;
    logic             mem_to_reg_o;
    logic             mem_read_o;
    logic             mem_write_o;
    logic             alu_src_o;
    logic [1:0]       alu_op_o;
    logic             stall_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] bubble_cnt_o;

    modport master (
        output valid_i, freeze_i, flush_i, opcode_i, funct_i, pc_i,
               rs1_data_i, rs2_data_i, imm_i, rs1_addr_i, rs2_addr_i, rd_addr_i,
               reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i, alu_src_i, alu_op_i,
        input  valid_o, pc_o, rs1_data_o, rs2_data_o, imm_o, funct_o,
               rs1_addr_o, rs2_addr_o, rd_addr_o, reg_write_o, mem_to_reg_o,
               mem_read_o, mem_write_o, alu_src_o, alu_op_o, stall_o,
               stall_cnt_o, bubble_cnt_o
    );

    modport slave (
        input  valid_i, freeze_i, flush_i, opcode_i, funct_i, pc_i,
               rs1_data_i, rs2_data_i, imm_i, rs1_addr_i, rs2_addr_i, rd_addr_i,
               reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i, alu_src_i, alu_op_i,
        output valid_o, pc_o, rs1_data_o, rs2_data_o, imm_o, funct_o,
               rs1_addr_o, rs2_addr_o, rd_addr_o, reg_write_o, mem_to_reg_o,
               mem_read_o, mem_write_o, alu_src_o, alu_op_o, stall_o,
               stall_cnt_o, bubble_cnt_o
    );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion
// and saturating stall/bubble performance counters.
module id_ex_pipe_reg #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    id_ex_pipe_reg_if.slave bus
);
    typedef enum logic [6:0] {
        OP_REG    = 7'b0110011,
        OP_IMM    = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011
    } opcode_e;

    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc;
    logic [XLEN-1:0]  ex_rs1_data;
    logic [XLEN-1:0]  ex_rs2_data;
    logic [XLEN-1:0]  ex_imm;
    logic [9:0]       ex_funct;
    logic [4:0]       ex_rs1_addr;
    logic [4:0]       ex_rs2_addr;
    logic [4:0]       ex_rd_addr;
    logic             ex_reg_write;
    logic             ex_mem_to_reg;
    logic             ex_mem_read;
    logic             ex_mem_write;
    logic             ex_alu_src;
    logic [1:0]       ex_alu_op;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    logic uses_rs1;
    logic uses_rs2;
    logic rs1_match;
    logic rs2_match;
    logic hazard;

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode_e'(bus.opcode_i))
            OP_REG, OP_STORE, OP_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_IMM, OP_LOAD: uses_rs1 = 1'b1;
            default: ;
        endcase
    end

    // x0 is never a real destination, so a load into it cannot create a dependency.
    always_comb begin
        rs1_match = uses_rs1 && (ex_rd_addr == bus.rs1_addr_i);
        rs2_match = uses_rs2 && (ex_rd_addr == bus.rs2_addr_i);
        hazard    = bus.valid_i && ex_valid && ex_mem_read &&
                    (ex_rd_addr != 5'd0) && (rs1_match || rs2_match);
    end

    assign bus.stall_o = hazard && !bus.flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_valid      <= 1'b0;
            ex_pc         <= '0;
            ex_rs1_data   <= '0;
            ex_rs2_data   <= '0;
            ex_imm        <= '0;
            ex_funct      <= '0;
            ex_rs1_addr   <= '0;
            ex_rs2_addr   <= '0;
            ex_rd_addr    <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_alu_op     <= '0;
            stall_cnt     <= '0;
            bubble_cnt    <= '0;
        end else if (!bus.freeze_i) begin
            if (bus.flush_i || hazard) begin
                // A flush swallows any concurrent hazard: one bubble, counted once.
                ex_valid      <= 1'b0;
                ex_pc         <= '0;
                ex_rs1_data   <= '0;
                ex_rs2_data   <= '0;
                ex_imm        <= '0;
                ex_funct      <= '0;
                ex_rs1_addr   <= '0;
                ex_rs2_addr   <= '0;
                ex_rd_addr    <= '0;
                ex_reg_write  <= 1'b0;
                ex_mem_to_reg <= 1'b0;
                ex_mem_read   <= 1'b0;
                ex_mem_write  <= 1'b0;
                ex_alu_src    <= 1'b0;
                ex_alu_op     <= '0;
                if (bubble_cnt != '1) begin
                    bubble_cnt <= bubble_cnt + CNT_W'(1);
                end
                if (!bus.flush_i && (stall_cnt != '1)) begin
                    stall_cnt <= stall_cnt + CNT_W'(1);
                end
            end else begin
                ex_valid      <= bus.valid_i;
                ex_pc         <= bus.pc_i;
                ex_rs1_data   <= bus.rs1_data_i;
                ex_rs2_data   <= bus.rs2_data_i;
                ex_imm        <= bus.imm_i;
                ex_funct      <= bus.funct_i;
                ex_rs1_addr   <= bus.rs1_addr_i;
                ex_rs2_addr   <= bus.rs2_addr_i;
                ex_rd_addr    <= bus.rd_addr_i;
                ex_reg_write  <= bus.reg_write_i  && bus.valid_i;
                ex_mem_to_reg <= bus.mem_to_reg_i && bus.valid_i;
                ex_mem_read   <= bus.mem_read_i   && bus.valid_i;
                ex_mem_write  <= bus.mem_write_i  && bus.valid_i;
                ex_alu_src    <= bus.alu_src_i    && bus.valid_i;
                ex_alu_op     <= bus.alu_op_i & {2{bus.valid_i}};
            end
        end
    end

    assign bus.valid_o      = ex_valid;
    assign bus.pc_o         = ex_pc;
    assign bus.rs1_data_o   = ex_rs1_data;
    assign bus.rs2_data_o   = ex_rs2_data;
    assign bus.imm_o        = ex_imm;
    assign bus.funct_o      = ex_funct;
    assign bus.rs1_addr_o   = ex_rs1_addr;
    assign bus.rs2_addr_o   = ex_rs2_addr;
    assign bus.rd_addr_o    = ex_rd_addr;
    assign bus.reg_write_o  = ex_reg_write;
    assign bus.mem_to_reg_o = ex_mem_to_reg;
    assign bus.mem_read_o   = ex_mem_read;
    assign bus.mem_write_o  = ex_mem_write;
    assign bus.alu_src_o    = ex_alu_src;
    assign bus.alu_op_o     = ex_alu_op;
    assign bus.stall_cnt_o  = stall_cnt;
    assign bus.bubble_cnt_o = bubble_cnt;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: directed hazard/flush/freeze/reset cases
// followed by random traffic, checked against a behavioural model.
module tb_id_ex_pipe_reg;
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    typedef struct packed {
        bit          valid, freeze, flush;
        logic [6:0]  op;
        logic [9:0]  funct;
        logic [31:0] pc, r1, r2, imm;
        logic [4:0]  a1, a2, rd;
        bit          rw, m2r, mr, mw, asrc;
        logic [1:0]  aop;
    } stim_t;

    typedef struct packed {
        bit          valid;
        logic [31:0] pc, r1, r2, imm;
        logic [9:0]  funct;
        logic [4:0]  a1, a2, rd;
        bit          rw, m2r, mr, mw, asrc;
        logic [1:0]  aop;
        int          scnt, bcnt;
    } ex_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    ex_t  model = '0;
    bit   pending = 1'b0;
    bit   stall_q[$];
    ex_t  state_q[$];

    id_ex_pipe_reg_if #(.XLEN(32), .CNT_W(CW)) bus ();

    id_ex_pipe_reg #(.XLEN(32), .CNT_W(CW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit reads_rs1(logic [6:0] op);
        return op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
    endfunction

    function automatic bit reads_rs2(logic [6:0] op);
        return op inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    // Load in EX whose destination is a source of the ID instruction.
    function automatic bit load_use(ex_t c, stim_t s);
        bit dep;
        dep = (reads_rs1(s.op) && c.rd == s.a1) || (reads_rs2(s.op) && c.rd == s.a2);
        return s.valid && c.valid && c.mr && c.rd != 0 && dep;
    endfunction

    function automatic int sat_inc(int v);
        return (v < SAT) ? v + 1 : SAT;
    endfunction

    function automatic ex_t next_ex(ex_t c, stim_t s);
        ex_t n;
        if (s.freeze) return c;
        n = '0;
        n.scnt = c.scnt;
        if (s.flush) begin
            n.bcnt = sat_inc(c.bcnt);
        end else if (load_use(c, s)) begin
            n.bcnt = sat_inc(c.bcnt);
            n.scnt = sat_inc(c.scnt);
        end else begin
            n.bcnt  = c.bcnt;
            n.valid = s.valid;
            n.pc = s.pc; n.r1 = s.r1; n.r2 = s.r2; n.imm = s.imm; n.funct = s.funct;
            n.a1 = s.a1; n.a2 = s.a2; n.rd = s.rd;
            n.rw   = s.rw   & s.valid;
            n.m2r  = s.m2r  & s.valid;
            n.mr   = s.mr   & s.valid;
            n.mw   = s.mw   & s.valid;
            n.asrc = s.asrc & s.valid;
            n.aop  = s.valid ? s.aop : 2'b00;
        end
        return n;
    endfunction

    function automatic stim_t instr(logic [6:0] op, logic [4:0] rd, logic [4:0] a1,
                                    logic [4:0] a2, logic [31:0] imm, bit mr);
        stim_t s = '0;
        s.valid = 1'b1;
        s.op = op; s.rd = rd; s.a1 = a1; s.a2 = a2; s.imm = imm; s.mr = mr;
        s.m2r = mr; s.rw = 1'b1; s.asrc = (op != 7'b0110011);
        s.pc = 32'h1000 + 32'(rd) * 4; s.r1 = 32'hA000_0000 | 32'(a1); s.r2 = 32'hB000_0000 | 32'(a2);
        s.funct = {7'd0, 3'(rd)};
        return s;
    endfunction

    task automatic drive(input stim_t s);
        bus.valid_i = s.valid; bus.freeze_i = s.freeze; bus.flush_i = s.flush;
        bus.opcode_i = s.op; bus.funct_i = s.funct; bus.pc_i = s.pc;
        bus.rs1_data_i = s.r1; bus.rs2_data_i = s.r2; bus.imm_i = s.imm;
        bus.rs1_addr_i = s.a1; bus.rs2_addr_i = s.a2; bus.rd_addr_i = s.rd;
        bus.reg_write_i = s.rw; bus.mem_to_reg_i = s.m2r; bus.mem_read_i = s.mr;
        bus.mem_write_i = s.mw; bus.alu_src_i = s.asrc; bus.alu_op_i = s.aop;
    endtask

    task automatic step(input stim_t s);
        @(posedge clk);
        #2;
        if (pending) state_q.push_back(model);
        drive(s);
        stall_q.push_back(load_use(model, s) && !s.flush);
        model = next_ex(model, s);
        pending = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(bus.valid_o), 0);
        chk({tag, "_data"}, 64'(bus.pc_o | bus.rs1_data_o | bus.rs2_data_o | bus.imm_o), 0);
        chk({tag, "_addr"}, 64'({bus.funct_o, bus.rs1_addr_o, bus.rs2_addr_o, bus.rd_addr_o}), 0);
        chk({tag, "_ctrl"}, 64'({bus.reg_write_o, bus.mem_to_reg_o, bus.mem_read_o,
                                 bus.mem_write_o, bus.alu_src_o, bus.alu_op_o}), 0);
        chk({tag, "_cnts"}, 64'({bus.stall_cnt_o, bus.bubble_cnt_o}), 0);
        chk({tag, "_stall"}, 64'(bus.stall_o), 0);
    endtask

    // Reset lands between edges, with whatever ID inputs are present still applied.
    task automatic reset_pulse();
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("midreset");
        drive('0);
        model = next_ex('0, '0);
        #1;
        rst = 1'b0;
        pending = 1'b1;
    endtask

    always @(negedge clk) begin
        if (stall_q.size() != 0) begin
            bit s;
            s = stall_q.pop_front();
            chk("stall_o", 64'(bus.stall_o), 64'(s));
        end
        if (state_q.size() != 0) begin
            ex_t e;
            e = state_q.pop_front();
            chk("valid_o", 64'(bus.valid_o), 64'(e.valid));
            chk("pc_o", 64'(bus.pc_o), 64'(e.pc));
            chk("rs1_data_o", 64'(bus.rs1_data_o), 64'(e.r1));
            chk("rs2_data_o", 64'(bus.rs2_data_o), 64'(e.r2));
            chk("imm_o", 64'(bus.imm_o), 64'(e.imm));
            chk("funct_o", 64'(bus.funct_o), 64'(e.funct));
            chk("addrs", 64'({bus.rs1_addr_o, bus.rs2_addr_o, bus.rd_addr_o}), 64'({e.a1, e.a2, e.rd}));
            chk("ctrl", 64'({bus.reg_write_o, bus.mem_to_reg_o, bus.mem_read_o, bus.mem_write_o,
                             bus.alu_src_o, bus.alu_op_o}),
                64'({e.rw, e.m2r, e.mr, e.mw, e.asrc, e.aop}));
            chk("stall_cnt_o", 64'(bus.stall_cnt_o), 64'(e.scnt));
            chk("bubble_cnt_o", 64'(bus.bubble_cnt_o), 64'(e.bcnt));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        drive('0);
        #1;
        check_all_zero("reset");
        #1;
        rst = 1'b0;

        // addi x5,x1,-4
        step(instr(7'b0010011, 5'd5, 5'd1, 5'd0, 32'hFFFF_FFFC, 1'b0));
        step('0);
        @(negedge clk); #1;
        chk("addi_imm", 64'(bus.imm_o), 64'hFFFF_FFFC);
        chk("addi_rd", 64'(bus.rd_addr_o), 5);
        chk("addi_valid_rw", 64'({bus.valid_o, bus.reg_write_o}), 2'b11);

        // ld x6 then add x7,x6,x2: one stall, add held and captured after the bubble
        step(instr(7'b0000011, 5'd6, 5'd1, 5'd0, 32'd8, 1'b1));
        step(instr(7'b0110011, 5'd7, 5'd6, 5'd2, 32'd0, 1'b0));
        step(instr(7'b0110011, 5'd7, 5'd6, 5'd2, 32'd0, 1'b0));
        @(negedge clk); #1;
        chk("loaduse_cnts", 64'({bus.stall_cnt_o, bus.bubble_cnt_o}), {4'd1, 4'd1});

        // ld x0 then consumer of x0; ld x6 then addi whose unused rs2 field is 6
        step(instr(7'b0000011, 5'd0, 5'd1, 5'd0, 32'd0, 1'b1));
        step(instr(7'b0110011, 5'd9, 5'd0, 5'd0, 32'd0, 1'b0));
        step(instr(7'b0000011, 5'd6, 5'd1, 5'd0, 32'd0, 1'b1));
        step(instr(7'b0010011, 5'd8, 5'd9, 5'd6, 32'd1, 1'b0));

        // flush together with a hazard
        step(instr(7'b0000011, 5'd6, 5'd1, 5'd0, 32'd0, 1'b1));
        s = instr(7'b0110011, 5'd7, 5'd6, 5'd2, 32'd0, 1'b0);
        s.flush = 1'b1;
        step(s);
        step('0);
        @(negedge clk); #1;
        chk("flush_cnts", 64'({bus.stall_cnt_o, bus.bubble_cnt_o}), {4'd1, 4'd2});

        // freeze for three cycles with a load in EX and a dependent consumer in ID
        step(instr(7'b0000011, 5'd6, 5'd1, 5'd0, 32'd4, 1'b1));
        for (int i = 0; i < 3; i++) begin
            s = instr(7'b0100011, 5'd3, 5'd2, 5'd6, 32'(i), 1'b0);
            s.freeze = 1'b1;
            step(s);
        end

        // reset while a load-use stall is active
        step(instr(7'b0110011, 5'd7, 5'd6, 5'd2, 32'd0, 1'b0));
        reset_pulse();

        // counter saturation
        for (int i = 0; i < 20; i++) begin
            step(instr(7'b0000011, 5'd6, 5'd1, 5'd0, 32'd0, 1'b1));
            step(instr(7'b0110011, 5'd7, 5'd6, 5'd2, 32'd0, 1'b0));
            step(instr(7'b0110011, 5'd7, 5'd6, 5'd2, 32'd0, 1'b0));
        end
        step('0);
        @(negedge clk); #1;
        chk("sat_stall_cnt", 64'(bus.stall_cnt_o), 15);
        chk("sat_bubble_cnt", 64'(bus.bubble_cnt_o), 15);

        reset_pulse();
        for (int i = 0; i < 400; i++) begin
            logic [6:0] ops [0:5];
            ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111};
            s = instr(ops[$urandom_range(0, 5)], 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom, $urandom_range(0, 1) == 1);
            s.valid  = ($urandom_range(0, 7) != 0);
            s.flush  = ($urandom_range(0, 9) == 0);
            s.freeze = ($urandom_range(0, 9) == 0);
            s.mw     = $urandom_range(0, 1) == 1;
            s.rw     = $urandom_range(0, 1) == 1;
            s.aop    = 2'($urandom_range(0, 3));
            s.pc     = $urandom;
            s.r1     = $urandom;
            s.r2     = $urandom;
            s.funct  = 10'($urandom);
            step(s);
        end
        step('0);
        @(negedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register that captures the immediate produced by the decode-stage immediate generator, together with register-file read data, register addresses and control signals, and presents them to EX.
- Contains the load-use hazard detector. On a hazard it stalls PC and IF/ID and inserts a bubble into EX.
- Keeps saturating stall and bubble counters for performance debug.

Parameters:
- XLEN, 32, datapath width of PC, register data and immediate.
- CNT_W, 16, width of each performance counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- valid_i  in  1  the ID-stage instruction is valid.
- freeze_i  in  1  global pipeline freeze from the memory system; holds all state.
- flush_i  in  1  squash the ID-stage instruction; EX receives a bubble.
- opcode_i  in  7  instr[6:0] of the ID instruction.
- funct_i  in  10  {instr[31:25], instr[14:12]}.
- pc_i  in  XLEN  PC of the ID instruction.
- rs1_data_i, rs2_data_i  in  XLEN  register-file read data.
- imm_i  in  XLEN  sign-extended immediate.
- rs1_addr_i, rs2_addr_i, rd_addr_i  in  5 each  register addresses.
- reg_write_i, mem_to_reg_i, mem_read_i, mem_write_i, alu_src_i  in  1 each  control signals.
- alu_op_i  in  2  ALU op class.
- valid_o  out  1  EX holds a real instruction.
- pc_o, rs1_data_o, rs2_data_o, imm_o  out  XLEN  registered copies of the inputs.
- funct_o  out  10; rs1_addr_o, rs2_addr_o, rd_addr_o  out  5 each.
- reg_write_o, mem_to_reg_o, mem_read_o, mem_write_o, alu_src_o  out  1 each; alu_op_o  out  2.
- stall_o  out  1  combinational; when 1, upstream must hold PC and IF/ID.
- stall_cnt_o, bubble_cnt_o  out  CNT_W  saturating counters.

Behaviour:
- Reset (asynchronous, rst_i=1): every registered output is 0, including valid_o, all control, all data and both counters. stall_o then evaluates to 0 because mem_read_o=0.
- Source-use decode from opcode_i:
  - uses_rs1 = 1 for 0110011, 0010011, 0000011, 0100011, 1100011; 0 otherwise.
  - uses_rs2 = 1 for 0110011, 0100011, 1100011; 0 otherwise.
- hazard = valid_i & valid_o & mem_read_o & (rd_addr_o != 0) & ((uses_rs1 & rd_addr_o == rs1_addr_i) | (uses_rs2 & rd_addr_o == rs2_addr_i)).
- stall_o = hazard & ~flush_i. Purely combinational, no registered latency.
- Per-edge update, priority highest first:
  1. freeze_i=1: all registers and counters hold. stall_o is still driven; upstream ignores it during freeze.
  2. flush_i=1: load a bubble. valid_o and all six control outputs become 0. Data and address fields are don't-care; the implementation loads 0. bubble_cnt increments.
  3. hazard=1: load a bubble as in step 2. bubble_cnt and stall_cnt each increment.
  4. otherwise: capture all inputs. valid_o=valid_i. Control outputs = control inputs AND valid_i, so an invalid instruction never writes.
- Latency: one cycle from ID inputs to EX outputs.
- A load-use stall lasts exactly one cycle. The next cycle the load has left EX (valid_o=0), so the hazard clears and the held instruction is captured.
- rd_addr_o=0 never causes a hazard.
- Back-to-back loads into the same rd each stall the following consumer independently.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- rst_i asserted mid-stall clears state immediately. stall_o deasserts in the same cycle, asynchronously via mem_read_o.
- flush_i together with a hazard: flush wins, stall_o=0, and the bubble is counted once in bubble_cnt only.

Test Plan:
- Reset: rst_i pulsed while outputs are nonzero -> all outputs 0 immediately, before any clock edge; stall_o=0.
- Plain capture: addi x5,x1,-4 (opcode 0010011, imm_i=0xFFFFFFFC, valid_i=1) -> next edge imm_o=0xFFFFFFFC, rd_addr_o=5, reg_write_o=1, valid_o=1, stall_o=0.
- Load-use: ld x6 captured, then add x7,x6,x2 in ID -> stall_o=1 for exactly one cycle; next edge valid_o=0 with controls 0; following edge the add is captured; stall_cnt=1, bubble_cnt=1.
- No false hazard:
  - ld x0 followed by a consumer of x0 -> stall_o=0.
  - ld x6 followed by addi x8,x9,1 with rs2_addr_i field=6 -> stall_o=0, because uses_rs2=0 for addi.
- Flush/freeze:
  - flush_i=1 together with a hazard -> stall_o=0, bubble inserted, bubble_cnt+1, stall_cnt unchanged.
  - freeze_i=1 for 3 cycles -> outputs and counters constant throughout.
- Saturation: with CNT_W=4, force 20 hazards -> stall_cnt_o stops at 15.
